// File: rtl/iter_controller.sv
// iter_controller: start/done sequencer that walks a datapath through a
// load cycle followed by a configurable number of enabled calculation
// cycles, with abort and optional held-done/acknowledge handshake.
module iter_controller #(
  parameter int CNT_W     = 4,
  parameter int DEF_ITERS = 8,
  parameter bit DONE_HOLD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ack,
  input  logic             abort,
  input  logic [CNT_W-1:0] iters,
  output logic             ld,
  output logic             en,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] iter_idx,
  output logic             last
);

  // DEF_ITERS may equal 2^CNT_W, so only its minus-one form fits the counter.
  localparam logic [CNT_W-1:0] DEF_M1 = CNT_W'(DEF_ITERS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    LOAD  = 3'd2,
    CALC  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] n_m1;
  logic             at_last;

  assign at_last = (cnt == n_m1);

  // present-state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // next-state decode; abort outranks every other request outside IDLE
  always_comb begin
    state_nxt = state;
    if (abort && state != IDLE) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = READY;
        READY:   if (!start) state_nxt = LOAD;
        LOAD:    state_nxt = CALC;
        CALC:    if (at_last) state_nxt = DONE;
        DONE:    if (!DONE_HOLD || ack) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // run length is captured on the start-release edge so later iters changes are ignored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_m1 <= '0;
    end else if (state == READY && !abort && !start) begin
      n_m1 <= (iters == '0) ? DEF_M1 : iters - CNT_W'(1);
    end
  end

  // iteration counter: counts only while calculating, parked at 0 elsewhere
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (state == CALC) begin
      if (!abort && !at_last) cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  // Moore outputs decoded from state and counter only
  always_comb begin
    ld       = (state == LOAD);
    en       = (state == CALC);
    done     = (state == DONE);
    busy     = (state != IDLE);
    iter_idx = en ? cnt : '0;
    last     = en && at_last;
  end

endmodule
